// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the MiniMIPS32 pipeline sequencer:
//   - STALL_BUS width and the stall vector constants (bit0 PC .. bit5 WB)
//   - 2-bit redirect FSM state encoding
//   - reset-enable level, reset PC and exception entry address
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int unsigned STALL_BUS_W = 6;

    localparam logic [STALL_BUS_W-1:0] STALL_MEM  = 6'b011111;
    localparam logic [STALL_BUS_W-1:0] STALL_EXE  = 6'b001111;
    localparam logic [STALL_BUS_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_BUS_W-1:0] STALL_IF   = 6'b000011;
    localparam logic [STALL_BUS_W-1:0] STALL_NONE = 6'b000000;

    localparam logic        RST_ENABLE     = 1'b1;
    localparam logic [31:0] PC_INIT        = 32'hBFC0_0000;
    localparam logic [31:0] EXC_ENTRY_ADDR = 32'hBFC0_0380;

    typedef enum logic [1:0] {
        PCS_IDLE     = 2'd0,
        PCS_WAIT_MEM = 2'd1,
        PCS_FLUSH    = 2'd2,
        PCS_FLUSH_T  = 2'd3
    } pcs_state_e;

endpackage

// File: rtl/pipe_ctrl_stall_prio_enc.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_stall_prio_enc
// The stall_prio_enc block: a purely combinational priority encoder that
// turns the per-stage stall requests into the STALL_BUS vector.
// Priority MEM > EXE > ID > IF; the WB bit is never set.
// Ports:
//   stallreq_if/id/exe/mem  in   per-stage stall requests
//   stall                   out  STALL_BUS vector
// ---------------------------------------------------------------------------
module pipe_ctrl_stall_prio_enc
    import pipe_ctrl_pkg::*;
(
    input  logic                   stallreq_if,
    input  logic                   stallreq_id,
    input  logic                   stallreq_exe,
    input  logic                   stallreq_mem,
    output logic [STALL_BUS_W-1:0] stall
);

    always_comb begin
        // NOTE: every branch assigns stall, so no latch can be inferred.
        if (stallreq_mem)      stall = STALL_MEM;
        else if (stallreq_exe) stall = STALL_EXE;
        else if (stallreq_id)  stall = STALL_ID;
        else if (stallreq_if)  stall = STALL_IF;
        else                   stall = STALL_NONE;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
// Central pipeline sequencer for the 5-stage MiniMIPS32 core. Merges the
// per-stage stall requests into STALL_BUS and sequences exception / ERET
// redirects (flush, optional delay-slot flush_t, redirect target).
// Optional build macro: STALL_WDOG_EN adds a stall watchdog (stall_timeout).
// Ports:
//   cpu_clk_50M, cpu_rst     clock, synchronous active-high reset
//   stallreq_if/id/exe/mem   per-stage stall requests
//   exc_valid/exc_is_eret    MEM-stage exception / ERET commit
//   exc_in_delay             faulting instruction is in a delay slot
//   cp0_epc                  ERET return address
//   stall                    STALL_BUS (bit0 PC .. bit5 WB)
//   flush, flush_t           redirect flush pulses
//   flush_target             PC to load on flush
//   exc_ack                  one-cycle exception-accepted pulse
//   stall_timeout            watchdog flag (STALL_WDOG_EN only)
// ---------------------------------------------------------------------------
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] PC_INIT    = pipe_ctrl_pkg::PC_INIT,
    parameter logic [31:0] EXC_ENTRY  = EXC_ENTRY_ADDR,
    parameter int unsigned WDOG_LIMIT = 1024
) (
    input  logic                   cpu_clk_50M,
    input  logic                   cpu_rst,
    input  logic                   stallreq_if,
    input  logic                   stallreq_id,
    input  logic                   stallreq_exe,
    input  logic                   stallreq_mem,
    input  logic                   exc_valid,
    input  logic                   exc_is_eret,
    input  logic                   exc_in_delay,
    input  logic [31:0]            cp0_epc,
    output logic [STALL_BUS_W-1:0] stall,
    output logic                   flush,
    output logic                   flush_t,
    output logic [31:0]            flush_target,
    output logic                   exc_ack
`ifdef STALL_WDOG_EN
    , output logic                 stall_timeout
`endif
);

    logic [STALL_BUS_W-1:0] prio_stall;
    logic [STALL_BUS_W-1:0] stall_d;

    pcs_state_e  state_q,        state_d;
    logic        flush_q,        flush_d;
    logic        flush_t_q,      flush_t_d;
    logic        exc_ack_q,      exc_ack_d;
    logic [31:0] flush_target_q, flush_target_d;
    // Exception context captured while the MEM stage is still busy.
    logic        lat_eret_q,     lat_eret_d;
    logic        lat_delay_q,    lat_delay_d;
    logic [31:0] lat_epc_q,      lat_epc_d;

    pipe_ctrl_stall_prio_enc u_stall_prio_enc (
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_exe (stallreq_exe),
        .stallreq_mem (stallreq_mem),
        .stall        (prio_stall)
    );

    always_comb begin
        state_d        = state_q;
        flush_d        = 1'b0;
        flush_t_d      = 1'b0;
        exc_ack_d      = 1'b0;
        flush_target_d = flush_target_q;
        lat_eret_d     = lat_eret_q;
        lat_delay_d    = lat_delay_q;
        lat_epc_d      = lat_epc_q;
        stall_d        = prio_stall;

        unique case (state_q)
            PCS_IDLE: begin
                if (exc_valid && !stallreq_mem) begin
                    // Accept cycle: freeze everything up to MEM while the
                    // redirect is registered.
                    stall_d        = STALL_MEM;
                    lat_delay_d    = exc_in_delay;
                    flush_target_d = exc_is_eret ? cp0_epc : EXC_ENTRY;
                    flush_d        = 1'b1;
                    exc_ack_d      = 1'b1;
                    state_d        = PCS_FLUSH;
                end else if (exc_valid) begin
                    lat_eret_d  = exc_is_eret;
                    lat_delay_d = exc_in_delay;
                    lat_epc_d   = cp0_epc;
                    state_d     = PCS_WAIT_MEM;
                end
            end
            PCS_WAIT_MEM: begin
                if (!stallreq_mem) begin
                    stall_d        = STALL_MEM;
                    flush_target_d = lat_eret_q ? lat_epc_q : EXC_ENTRY;
                    flush_d        = 1'b1;
                    exc_ack_d      = 1'b1;
                    state_d        = PCS_FLUSH;
                end
            end
            PCS_FLUSH: begin
                // Stall requests and new exceptions come from instructions
                // being flushed, so both are ignored here.
                stall_d = STALL_NONE;
                if (lat_delay_q) begin
                    flush_t_d = 1'b1;
                    state_d   = PCS_FLUSH_T;
                end else begin
                    state_d   = PCS_IDLE;
                end
            end
            PCS_FLUSH_T: begin
                stall_d = STALL_NONE;
                state_d = PCS_IDLE;
            end
            default: state_d = PCS_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst == RST_ENABLE) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            state_q        <= PCS_IDLE;
            flush_q        <= 1'b0;
            flush_t_q      <= 1'b0;
            exc_ack_q      <= 1'b0;
            flush_target_q <= PC_INIT;
            lat_eret_q     <= 1'b0;
            lat_delay_q    <= 1'b0;
            lat_epc_q      <= 32'h0;
        end else begin
            state_q        <= state_d;
            flush_q        <= flush_d;
            flush_t_q      <= flush_t_d;
            exc_ack_q      <= exc_ack_d;
            flush_target_q <= flush_target_d;
            lat_eret_q     <= lat_eret_d;
            lat_delay_q    <= lat_delay_d;
            lat_epc_q      <= lat_epc_d;
        end
    end

    assign stall        = stall_d;
    assign flush        = flush_q;
    assign flush_t      = flush_t_q;
    assign flush_target = flush_target_q;
    assign exc_ack      = exc_ack_q;

`ifdef STALL_WDOG_EN
    logic [15:0] wdog_cnt_q, wdog_cnt_d;
    logic        wdog_active;

    assign wdog_active = stall_d[0] &&
                         (state_q == PCS_IDLE || state_q == PCS_WAIT_MEM);

    always_comb begin
        wdog_cnt_d = 16'h0;
        if (wdog_active) begin
            wdog_cnt_d = (wdog_cnt_q == 16'hFFFF) ? wdog_cnt_q : wdog_cnt_q + 16'h1;
        end
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst == RST_ENABLE) wdog_cnt_q <= 16'h0;
        else                       wdog_cnt_q <= wdog_cnt_d;
    end

    assign stall_timeout = (32'(wdog_cnt_q) >= WDOG_LIMIT);
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl
// Directed self-checking bench for pipe_ctrl. Inputs change 1 ns after the
// rising edge; combinational and registered outputs are sampled 1-2 ns after
// that, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        sr_if, sr_id, sr_exe, sr_mem;
    logic        exc_valid, exc_is_eret, exc_in_delay;
    logic [31:0] cp0_epc;
    logic [5:0]  stall;
    logic        flush, flush_t, exc_ack;
    logic [31:0] flush_target;
`ifdef STALL_WDOG_EN
    logic        stall_timeout;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.WDOG_LIMIT(4)) dut (
        .cpu_clk_50M  (clk),
        .cpu_rst      (rst),
        .stallreq_if  (sr_if),
        .stallreq_id  (sr_id),
        .stallreq_exe (sr_exe),
        .stallreq_mem (sr_mem),
        .exc_valid    (exc_valid),
        .exc_is_eret  (exc_is_eret),
        .exc_in_delay (exc_in_delay),
        .cp0_epc      (cp0_epc),
        .stall        (stall),
        .flush        (flush),
        .flush_t      (flush_t),
        .flush_target (flush_target),
        .exc_ack      (exc_ack)
`ifdef STALL_WDOG_EN
        , .stall_timeout (stall_timeout)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        sr_if = 0; sr_id = 0; sr_exe = 0; sr_mem = 0;
        exc_valid = 0; exc_is_eret = 0; exc_in_delay = 0;
        cp0_epc = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1;
        clear_inputs();
        step();
        step();
        #1;
        checks++; if (stall !== 6'h00) begin failures++; $display("FAIL reset_stall got=%h exp=00", stall); end
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b exp=0", flush); end
        checks++; if (flush_t !== 1'b0) begin failures++; $display("FAIL reset_flush_t got=%b exp=0", flush_t); end
        checks++; if (exc_ack !== 1'b0) begin failures++; $display("FAIL reset_exc_ack got=%b exp=0", exc_ack); end
        checks++; if (flush_target !== 32'hBFC00000) begin failures++; $display("FAIL reset_target got=%h exp=bfc00000", flush_target); end
        rst = 0;
        step();
    endtask

    task automatic test_stall_prio();
        // {mem, exe, id, if} -> expected stall vector
        logic [3:0] req [6];
        logic [5:0] exp [6];
        req[0] = 4'b0010; exp[0] = 6'h07;
        req[1] = 4'b0110; exp[1] = 6'h0F;
        req[2] = 4'b1110; exp[2] = 6'h1F;
        req[3] = 4'b0000; exp[3] = 6'h00;
        req[4] = 4'b0001; exp[4] = 6'h03;
        req[5] = 4'b1001; exp[5] = 6'h1F;
        for (int i = 0; i < 6; i++) begin
            {sr_mem, sr_exe, sr_id, sr_if} = req[i];
            #1;
            checks++; if (stall !== exp[i]) begin failures++; $display("FAIL prio_%0d got=%h exp=%h", i, stall, exp[i]); end
            checks++; if (flush !== 1'b0) begin failures++; $display("FAIL prio_flush_%0d got=%b exp=0", i, flush); end
            step();
        end
        clear_inputs();
        step();
    endtask

    task automatic test_plain_exc();
        exc_valid = 1; exc_in_delay = 0; exc_is_eret = 0; cp0_epc = 32'h1234_5678;
        #1;
        checks++; if (stall !== 6'h1F) begin failures++; $display("FAIL plain_accept_stall got=%h exp=1f", stall); end
        step();  // N+1: FLUSH; a fresh exception and stall request must be ignored
        exc_valid = 1; exc_is_eret = 1; cp0_epc = 32'hDEAD_BEE0; sr_id = 1;
        #1;
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL plain_flush got=%b exp=1", flush); end
        checks++; if (flush_target !== 32'hBFC00380) begin failures++; $display("FAIL plain_target got=%h exp=bfc00380", flush_target); end
        checks++; if (exc_ack !== 1'b1) begin failures++; $display("FAIL plain_ack got=%b exp=1", exc_ack); end
        checks++; if (flush_t !== 1'b0) begin failures++; $display("FAIL plain_flush_t1 got=%b exp=0", flush_t); end
        checks++; if (stall !== 6'h00) begin failures++; $display("FAIL plain_flush_stall got=%h exp=00", stall); end
        step();  // N+2
        clear_inputs();
        #1;
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL plain_flush_end got=%b exp=0", flush); end
        checks++; if (flush_t !== 1'b0) begin failures++; $display("FAIL plain_flush_t2 got=%b exp=0", flush_t); end
        checks++; if (exc_ack !== 1'b0) begin failures++; $display("FAIL plain_ack_end got=%b exp=0", exc_ack); end
        checks++; if (flush_target !== 32'hBFC00380) begin failures++; $display("FAIL plain_target_hold got=%h exp=bfc00380", flush_target); end
        step();
        #1;
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL plain_no_reaccept got=%b exp=0", flush); end
    endtask

    task automatic test_delay_eret();
        exc_valid = 1; exc_is_eret = 1; exc_in_delay = 1; cp0_epc = 32'hBFC00104;
        #1;
        checks++; if (stall !== 6'h1F) begin failures++; $display("FAIL eret_accept_stall got=%h exp=1f", stall); end
        step();  // N+1
        clear_inputs();
        #1;
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL eret_flush got=%b exp=1", flush); end
        checks++; if (flush_target !== 32'hBFC00104) begin failures++; $display("FAIL eret_target got=%h exp=bfc00104", flush_target); end
        checks++; if (flush_t !== 1'b0) begin failures++; $display("FAIL eret_flush_t_early got=%b exp=0", flush_t); end
        checks++; if (stall !== 6'h00) begin failures++; $display("FAIL eret_stall_n1 got=%h exp=00", stall); end
        checks++; if (exc_ack !== 1'b1) begin failures++; $display("FAIL eret_ack got=%b exp=1", exc_ack); end
        step();  // N+2: FLUSH_T with a masked stall request
        sr_exe = 1;
        #1;
        checks++; if (flush_t !== 1'b1) begin failures++; $display("FAIL eret_flush_t got=%b exp=1", flush_t); end
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL eret_flush_n2 got=%b exp=0", flush); end
        checks++; if (stall !== 6'h00) begin failures++; $display("FAIL eret_stall_n2 got=%h exp=00", stall); end
        checks++; if (exc_ack !== 1'b0) begin failures++; $display("FAIL eret_ack_n2 got=%b exp=0", exc_ack); end
        step();  // N+3
        clear_inputs();
        #1;
        checks++; if (flush_t !== 1'b0) begin failures++; $display("FAIL eret_flush_t_end got=%b exp=0", flush_t); end
        checks++; if (flush_target !== 32'hBFC00104) begin failures++; $display("FAIL eret_target_hold got=%h exp=bfc00104", flush_target); end
        step();
    endtask

    task automatic test_mem_stall_exc();
        exc_valid = 1; exc_is_eret = 1; exc_in_delay = 0; cp0_epc = 32'hBFC00200; sr_mem = 1;
        #1;
        checks++; if (stall !== 6'h1F) begin failures++; $display("FAIL memx_stall0 got=%h exp=1f", stall); end
        for (int i = 1; i < 3; i++) begin
            step();
            exc_valid = 0; cp0_epc = 32'h0000_1000 + 32'(i);
            #1;
            checks++; if (flush !== 1'b0) begin failures++; $display("FAIL memx_noflush_%0d got=%b exp=0", i, flush); end
            checks++; if (exc_ack !== 1'b0) begin failures++; $display("FAIL memx_noack_%0d got=%b exp=0", i, exc_ack); end
            checks++; if (stall !== 6'h1F) begin failures++; $display("FAIL memx_stall_%0d got=%h exp=1f", i, stall); end
        end
        step();  // MEM done: accept cycle from latched context
        sr_mem = 0; sr_if = 1;
        #1;
        checks++; if (stall !== 6'h1F) begin failures++; $display("FAIL memx_accept_stall got=%h exp=1f", stall); end
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL memx_accept_flush got=%b exp=0", flush); end
        step();
        clear_inputs();
        #1;
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL memx_flush got=%b exp=1", flush); end
        checks++; if (flush_target !== 32'hBFC00200) begin failures++; $display("FAIL memx_target got=%h exp=bfc00200", flush_target); end
        checks++; if (exc_ack !== 1'b1) begin failures++; $display("FAIL memx_ack got=%b exp=1", exc_ack); end
        step();
        #1;
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL memx_flush_end got=%b exp=0", flush); end
        checks++; if (flush_t !== 1'b0) begin failures++; $display("FAIL memx_flush_t got=%b exp=0", flush_t); end
        step();
    endtask

    task automatic test_reset_mid();
        exc_valid = 1; exc_is_eret = 0; exc_in_delay = 1;
        step();  // FLUSH cycle
        clear_inputs();
        #1;
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL rstmid_flush got=%b exp=1", flush); end
        rst = 1;
        step();
        #1;
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL rstmid_flush_after got=%b exp=0", flush); end
        checks++; if (flush_t !== 1'b0) begin failures++; $display("FAIL rstmid_flush_t got=%b exp=0", flush_t); end
        checks++; if (flush_target !== 32'hBFC00000) begin failures++; $display("FAIL rstmid_target got=%h exp=bfc00000", flush_target); end
        rst = 0;
        step();
        #1;
        checks++; if (flush_t !== 1'b0) begin failures++; $display("FAIL rstmid_flush_t_late got=%b exp=0", flush_t); end
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL rstmid_flush_late got=%b exp=0", flush); end
    endtask

`ifdef STALL_WDOG_EN
    task automatic test_watchdog();
        clear_inputs();
        step();
        sr_if = 1;
        #1;
        checks++; if (stall_timeout !== 1'b0) begin failures++; $display("FAIL wdog_start got=%b exp=0", stall_timeout); end
        for (int i = 1; i <= 4; i++) begin
            step();
            #1;
            checks++; if (stall_timeout !== (i >= 4)) begin failures++; $display("FAIL wdog_cnt_%0d got=%b exp=%b", i, stall_timeout, (i >= 4)); end
        end
        sr_if = 0;
        #1;
        checks++; if (stall_timeout !== 1'b1) begin failures++; $display("FAIL wdog_hold got=%b exp=1", stall_timeout); end
        step();
        #1;
        checks++; if (stall_timeout !== 1'b0) begin failures++; $display("FAIL wdog_clear got=%b exp=0", stall_timeout); end
    endtask
`endif

    initial begin
        test_reset();
        test_stall_prio();
        test_plain_exc();
        test_delay_eret();
        test_mem_stall_exc();
        test_reset_mid();
`ifdef STALL_WDOG_EN
        test_watchdog();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
